// File: rtl/regsr_pkg.sv
// Shared types and defaults for the set/reset register bank command controller.
package regsr_pkg;

    localparam int DEF_NUM_REGS = 8;
    localparam int DEF_WIDTH    = 32;

    // Command opcodes as they appear on cmd_op.
    typedef enum logic [1:0] {
        OP_READ  = 2'b00,
        OP_WRITE = 2'b01,
        OP_SET   = 2'b10,
        OP_CLEAR = 2'b11
    } op_t;

    // Controller sequence: accept, strobe, let the bank settle, respond.
    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        DRIVE  = 2'b01,
        SETTLE = 2'b10,
        RESP   = 2'b11
    } state_t;

endpackage

// File: rtl/regsr_expect.sv
// regsr_expect: value a register should hold after a command is applied to
// its previous contents. Purely combinational.
module regsr_expect
    import regsr_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [1:0]       op_i,
    input  logic [WIDTH-1:0] old_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] expect_o
);

    // Apply the opcode to the old value; READ leaves it unchanged.
    always_comb begin
        // NOTE: the output gets a default before the case so no path leaves it unassigned (no latch).
        expect_o = old_i;
        case (op_t'(op_i))
            OP_WRITE: expect_o = wdata_i;
            OP_SET:   expect_o = old_i | wdata_i;
            OP_CLEAR: expect_o = old_i & ~wdata_i;
            default:  expect_o = old_i;
        endcase
    end

endmodule

// File: rtl/regsr_cmd_ctrl.sv
// regsr_cmd_ctrl: command-side controller for the set/reset register bank.
// Accepts one READ/WRITE/SET_BITS/CLEAR_BITS command at a time, drives a
// single-cycle strobe into the addressed register, waits for the bank to
// settle, then returns the readback value and a mismatch flag.
module regsr_cmd_ctrl
    import regsr_pkg::*;
#(
    parameter int NUM_REGS      = DEF_NUM_REGS,
    parameter int WIDTH         = DEF_WIDTH,
    parameter int SETTLE_CYCLES = 1,
    localparam int AW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
    input  logic                      clk,
    input  logic                      global_reset,
    // command channel
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic [1:0]                cmd_op,
    input  logic [AW-1:0]             cmd_addr,
    input  logic [WIDTH-1:0]          cmd_wdata,
    // response channel
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [WIDTH-1:0]          rsp_rdata,
    output logic                      rsp_err,
    // register bank interface
    output logic [WIDTH-1:0]          reg_data,
    output logic [NUM_REGS-1:0]       reg_we,
    output logic [NUM_REGS*WIDTH-1:0] reg_set,
    output logic [NUM_REGS*WIDTH-1:0] reg_reset,
    input  logic [NUM_REGS*WIDTH-1:0] reg_out
);

    localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    // Latched command and bookkeeping
    state_t                    state_q;
    op_t                       op_q;
    logic [AW-1:0]             addr_q;
    logic [WIDTH-1:0]          wdata_q;
    logic [WIDTH-1:0]          old_q;
    logic                      addr_ok_q;
    logic [CW-1:0]             settle_cnt_q;

    // Registered outputs
    logic                      rsp_valid_q;
    logic [WIDTH-1:0]          rsp_rdata_q;
    logic                      rsp_err_q;
    logic [WIDTH-1:0]          reg_data_q;
    logic [NUM_REGS-1:0]       reg_we_q;
    logic [NUM_REGS*WIDTH-1:0] reg_set_q;
    logic [NUM_REGS*WIDTH-1:0] reg_reset_q;

    // Strobe values loaded at command acceptance, shown in the DRIVE cycle
    logic [WIDTH-1:0]          reg_data_d;
    logic [NUM_REGS-1:0]       reg_we_d;
    logic [NUM_REGS*WIDTH-1:0] reg_set_d;
    logic [NUM_REGS*WIDTH-1:0] reg_reset_d;

    // Bank words selected by the incoming and the latched address
    logic [WIDTH-1:0]          cmd_word;
    logic [WIDTH-1:0]          rb_word;
    logic                      cmd_addr_ok;
    logic [WIDTH-1:0]          expect_val;
    op_t                       cmd_op_e;

    assign cmd_op_e    = op_t'(cmd_op);
    assign cmd_addr_ok = ({1'b0, cmd_addr} < (AW + 1)'(NUM_REGS));

    // Word muxes and next strobe pattern; out-of-range addresses select nothing.
    always_comb begin
        cmd_word    = '0;
        rb_word     = '0;
        reg_we_d    = '0;
        reg_set_d   = '0;
        reg_reset_d = '0;
        reg_data_d  = (cmd_addr_ok && cmd_op_e == OP_WRITE) ? cmd_wdata : '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (cmd_addr == AW'(i)) begin
                cmd_word    = reg_out[i*WIDTH +: WIDTH];
                reg_we_d[i] = (cmd_op_e == OP_WRITE);
                if (cmd_op_e == OP_SET)   reg_set_d[i*WIDTH +: WIDTH]   = cmd_wdata;
                if (cmd_op_e == OP_CLEAR) reg_reset_d[i*WIDTH +: WIDTH] = cmd_wdata;
            end
            if (addr_q == AW'(i)) begin
                rb_word = reg_out[i*WIDTH +: WIDTH];
            end
        end
    end

    regsr_expect #(
        .WIDTH (WIDTH)
    ) u_expect (
        .op_i     (op_q),
        .old_i    (old_q),
        .wdata_i  (wdata_q),
        .expect_o (expect_val)
    );

    // Command sequencer with all outputs registered; reset drops every strobe at once.
    always_ff @(posedge clk or negedge global_reset) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!global_reset) begin
            state_q      <= IDLE;
            op_q         <= OP_READ;
            addr_q       <= '0;
            wdata_q      <= '0;
            old_q        <= '0;
            addr_ok_q    <= 1'b0;
            settle_cnt_q <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_rdata_q  <= '0;
            rsp_err_q    <= 1'b0;
            reg_data_q   <= '0;
            reg_we_q     <= '0;
            reg_set_q    <= '0;
            reg_reset_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cmd_valid) begin
                        op_q        <= cmd_op_e;
                        addr_q      <= cmd_addr;
                        wdata_q     <= cmd_wdata;
                        old_q       <= cmd_word;
                        addr_ok_q   <= cmd_addr_ok;
                        reg_data_q  <= reg_data_d;
                        reg_we_q    <= cmd_addr_ok ? reg_we_d    : '0;
                        reg_set_q   <= cmd_addr_ok ? reg_set_d   : '0;
                        reg_reset_q <= cmd_addr_ok ? reg_reset_d : '0;
                        state_q     <= DRIVE;
                    end
                end
                DRIVE: begin
                    reg_data_q   <= '0;
                    reg_we_q     <= '0;
                    reg_set_q    <= '0;
                    reg_reset_q  <= '0;
                    settle_cnt_q <= '0;
                    state_q      <= SETTLE;
                end
                SETTLE: begin
                    if (settle_cnt_q == CW'(SETTLE_CYCLES - 1)) begin
                        rsp_rdata_q <= addr_ok_q ? rb_word : '0;
                        rsp_err_q   <= !addr_ok_q ||
                                       ((op_q != OP_READ) && (rb_word != expect_val));
                        rsp_valid_q <= 1'b1;
                        state_q     <= RESP;
                    end else begin
                        settle_cnt_q <= settle_cnt_q + 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign cmd_ready = (state_q == IDLE);
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign reg_data  = reg_data_q;
    assign reg_we    = reg_we_q;
    assign reg_set   = reg_set_q;
    assign reg_reset = reg_reset_q;

endmodule

// File: tb/tb_regsr_cmd_ctrl.sv
// Testbench for regsr_cmd_ctrl: behavioural set/reset bank, reference model
// of register contents, response scoreboard, directed and random commands.
module tb_regsr_cmd_ctrl;

    localparam int N  = 8;
    localparam int W  = 32;
    localparam int AW = 3;

    logic             clk = 1'b0;
    logic             global_reset;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [AW-1:0]    cmd_addr;
    logic [W-1:0]     cmd_wdata;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [W-1:0]     rsp_rdata;
    logic             rsp_err;
    logic [W-1:0]     reg_data;
    logic [N-1:0]     reg_we;
    logic [N*W-1:0]   reg_set;
    logic [N*W-1:0]   reg_reset;
    logic [N*W-1:0]   reg_out;

    always #5 clk = ~clk;

    regsr_cmd_ctrl #(
        .NUM_REGS      (N),
        .WIDTH         (W),
        .SETTLE_CYCLES (1)
    ) dut (
        .clk          (clk),
        .global_reset (global_reset),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_op       (cmd_op),
        .cmd_addr     (cmd_addr),
        .cmd_wdata    (cmd_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err),
        .reg_data     (reg_data),
        .reg_we       (reg_we),
        .reg_set      (reg_set),
        .reg_reset    (reg_reset),
        .reg_out      (reg_out)
    );

    // ------------------------------------------------------------------
    // Behavioural register bank (the thing being driven); word 5 can be
    // forced to read as zero to emulate a stuck output.
    // ------------------------------------------------------------------
    logic [W-1:0] bank [N] = '{default: '0};
    logic         stuck5 = 1'b0;

    always @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            logic [W-1:0] v;
            v = reg_we[i] ? reg_data : bank[i];
            bank[i] <= (v | reg_set[i*W +: W]) & ~reg_reset[i*W +: W];
        end
    end

    always_comb begin
        reg_out = '0;
        for (int i = 0; i < N; i++) begin
            reg_out[i*W +: W] = (stuck5 && i == 5) ? '0 : bank[i];
        end
    end

    // ------------------------------------------------------------------
    // Counters and check()
    // ------------------------------------------------------------------
    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [N*W-1:0] act, input logic [N*W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: register contents as a plain array, responses queued
    // ------------------------------------------------------------------
    typedef struct packed {
        logic [W-1:0] rdata;
        logic         err;
    } rsp_t;

    rsp_t         exp_q[$];
    logic [W-1:0] model_mem [N] = '{default: '0};

    function automatic logic [W-1:0] visible(input int a);
        return (stuck5 && a == 5) ? '0 : model_mem[a];
    endfunction

    function automatic void model_apply(input logic [1:0] op, input int a, input logic [W-1:0] w);
        logic [W-1:0] old_v;
        logic [W-1:0] intended;
        rsp_t         r;
        old_v = visible(a);
        case (op)
            2'd1:    intended = w;
            2'd2:    intended = old_v | w;
            2'd3:    intended = old_v & ~w;
            default: intended = old_v;
        endcase
        case (op)
            2'd1:    model_mem[a] = w;
            2'd2:    model_mem[a] = model_mem[a] | w;
            2'd3:    model_mem[a] = model_mem[a] & ~w;
            default: ;
        endcase
        r.rdata = visible(a);
        r.err   = (op != 2'd0) && (r.rdata != intended);
        exp_q.push_back(r);
    endfunction

    // Monitor: every response handshake pops the next expected response.
    always @(negedge clk) begin
        if (global_reset && rsp_valid && rsp_ready) begin
            rsp_t e;
            check("rsp_expected", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("rsp_rdata", rsp_rdata, e.rdata);
                check("rsp_err", rsp_err, e.err);
            end
        end
    end

    // Set and reset masks must never overlap on any bit.
    always @(negedge clk) begin
        if (global_reset) check("set_reset_overlap", reg_set & reg_reset, 0);
    end

    // Response back-pressure: random unless a test holds it low.
    logic stall_rsp = 1'b1;
    initial begin
        rsp_ready = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            rsp_ready = stall_rsp ? 1'b0 : ($urandom_range(0, 3) != 0);
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    // Present a command, wait for acceptance; returns #1 after the accept edge.
    task automatic send_cmd(input logic [1:0] op, input int addr, input logic [W-1:0] wdata, input bit track);
        int waited;
        bit acc;
        waited    = 0;
        acc       = 1'b0;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_addr  = AW'(addr);
        cmd_wdata = wdata;
        while (!acc && waited < 300) begin
            @(negedge clk);
            if (cmd_ready) acc = 1'b1;
            else waited++;
        end
        check("cmd_accept", acc, 1);
        if (acc && track) model_apply(op, addr, wdata);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || !cmd_ready) && n < 500) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain", exp_q.size(), 0);
    endtask

    // Watchdog so the run always ends.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------
    initial begin
        logic [N*W-1:0] bus;
        logic [W-1:0]   held;
        logic [1:0]     op;
        int             a;
        logic [W-1:0]   w;

        global_reset = 1'b0;
        cmd_valid    = 1'b0;
        cmd_op       = 2'd0;
        cmd_addr     = '0;
        cmd_wdata    = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_rdata", rsp_rdata, 0);
        check("rst_rsp_err", rsp_err, 0);
        check("rst_reg_data", reg_data, 0);
        check("rst_reg_we", reg_we, 0);
        check("rst_reg_set", reg_set, 0);
        check("rst_reg_reset", reg_reset, 0);
        global_reset = 1'b1;
        @(posedge clk);
        #1;
        check("rst_cmd_ready", cmd_ready, 1);

        // WRITE 3 <- DEADBEEF, with latency check
        stall_rsp = 1'b1;
        send_cmd(2'd1, 3, 32'hDEADBEEF, 1'b1);
        check("wr_we", reg_we, 8'b0000_1000);
        check("wr_data", reg_data, 32'hDEADBEEF);
        check("wr_set", reg_set, 0);
        check("wr_busy", cmd_ready, 0);
        @(posedge clk);
        #1;
        check("wr_we_drop", reg_we, 0);
        check("wr_rsp_early", rsp_valid, 0);
        @(posedge clk);
        #1;
        check("wr_rsp_cycle3", rsp_valid, 1);
        check("wr_rdata_direct", rsp_rdata, 32'hDEADBEEF);
        stall_rsp = 1'b0;
        wait_idle();

        // SET 3 mask F0
        send_cmd(2'd2, 3, 32'h0000_00F0, 1'b1);
        bus = '0;
        bus[3*W +: W] = 32'h0000_00F0;
        check("set_mask", reg_set, bus);
        check("set_no_reset", reg_reset, 0);
        check("set_no_we", reg_we, 0);
        wait_idle();

        // CLEAR 3 mask FFFF0000
        send_cmd(2'd3, 3, 32'hFFFF_0000, 1'b1);
        bus = '0;
        bus[3*W +: W] = 32'hFFFF_0000;
        check("clr_mask", reg_reset, bus);
        check("clr_no_set", reg_set, 0);
        wait_idle();

        // READ 3: no strobes
        send_cmd(2'd0, 3, 32'h5555_AAAA, 1'b1);
        check("rd_no_we", reg_we, 0);
        check("rd_no_set", reg_set, 0);
        check("rd_no_reset", reg_reset, 0);
        wait_idle();

        // Stuck output on register 5
        stuck5 = 1'b1;
        send_cmd(2'd1, 5, 32'h0000_0001, 1'b1);
        wait_idle();
        stuck5 = 1'b0;

        // Response stall with a second command pending
        stall_rsp = 1'b1;
        send_cmd(2'd0, 2, '0, 1'b1);
        held = visible(2);
        repeat (2) @(posedge clk);
        #1;
        cmd_valid = 1'b1;
        cmd_op    = 2'd1;
        cmd_addr  = AW'(4);
        cmd_wdata = 32'hA5A5_0F0F;
        for (int i = 0; i < 10; i++) begin
            check("stall_valid", rsp_valid, 1);
            check("stall_rdata", rsp_rdata, held);
            check("stall_cmd_ready", cmd_ready, 0);
            check("stall_we", reg_we, 0);
            check("stall_set", reg_set | reg_reset, 0);
            @(posedge clk);
            #1;
        end
        stall_rsp = 1'b0;
        send_cmd(2'd1, 4, 32'hA5A5_0F0F, 1'b1);
        wait_idle();

        // Asynchronous reset in the DRIVE cycle aborts the command
        send_cmd(2'd1, 6, 32'h1234_5678, 1'b0);
        check("abort_we_pre", reg_we, 8'b0100_0000);
        #1;
        global_reset = 1'b0;
        #1;
        check("abort_we", reg_we, 0);
        check("abort_data", reg_data, 0);
        check("abort_set", reg_set, 0);
        check("abort_reset", reg_reset, 0);
        repeat (2) @(posedge clk);
        #1;
        global_reset = 1'b1;
        @(posedge clk);
        #1;
        check("post_abort_ready", cmd_ready, 1);
        check("post_abort_valid", rsp_valid, 0);
        repeat (5) @(posedge clk);
        #1;
        check("post_abort_no_rsp", rsp_valid, 0);

        // Random commands against the model
        for (int k = 0; k < 60; k++) begin
            op = 2'($urandom_range(0, 3));
            a  = int'($urandom_range(0, N - 1));
            case ($urandom_range(0, 5))
                0:       w = '0;
                1:       w = '1;
                default: w = $urandom;
            endcase
            send_cmd(op, a, w, 1'b1);
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
        end
        wait_idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
